// File: rtl/trap_pkg.sv
// rtl/trap_pkg.sv - shared types and constants for the trap sequencer
package trap_pkg;

  typedef enum logic [1:0] {IDLE, DRAIN, TRAP, REDIRECT} state_t;
  typedef enum logic [1:0] {INT, EXC, RET} kind_t;

  localparam logic [4:0] MEI = 5'd11;
  localparam logic [4:0] MSI = 5'd3;
  localparam logic [4:0] MTI = 5'd7;

  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

endpackage

// File: rtl/int_prio_enc.sv
// rtl/int_prio_enc.sv - machine interrupt priority encoder
// Order: MEI, MSI, MTI, then platform bits 16 and up, lowest index first.
module int_prio_enc
  import trap_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pend,
  input  logic            en,
  output logic            valid,
  output logic [4:0]      index
);

  logic [XLEN-1:0] gated;
  assign gated = pend & {XLEN{en}};

  // Later assignments override earlier ones, so the loop runs from the
  // lowest priority upward.
  always_comb begin
    valid = 1'b0;
    index = 5'd0;
    for (int i = XLEN - 1; i >= 16; i--) begin
      if (gated[i]) begin
        valid = 1'b1;
        index = 5'(i);
      end
    end
    if (gated[MTI]) begin
      valid = 1'b1;
      index = MTI;
    end
    if (gated[MSI]) begin
      valid = 1'b1;
      index = MSI;
    end
    if (gated[MEI]) begin
      valid = 1'b1;
      index = MEI;
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - arbitrates traps/mret, drains the pipe, pulses
// the CSR action and redirects fetch.
module trap_sequencer
  import trap_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DRAIN_MAX = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] mip,
  input  logic [XLEN-1:0] mie,
  input  logic            MIE,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  input  logic            exc_valid,
  input  logic [4:0]      exc_code,
  input  logic            mret_valid,
  input  logic [XLEN-1:0] commit_pc,
  input  logic            pipe_empty,
  output logic            stall_fetch,
  output logic            flush,
  output logic            int_action,
  output logic            exp_action,
  output logic            ret_action,
  output logic [4:0]      int_code,
  output logic [XLEN-1:0] current_pc,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy
);

  localparam int CNT_W = $clog2(DRAIN_MAX + 1);

  state_t            state, state_n;
  kind_t             kind_q, kind_n;
  logic [4:0]        cause_q, cause_n;
  logic [XLEN-1:0]   pc_q, pc_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;

  logic [XLEN-1:0]   pend;
  logic              int_valid;
  logic [4:0]        int_index;
  logic              still_pending;
  logic [XLEN-1:0]   vec_base;
  logic [XLEN-1:0]   vec_offset;

  assign pend = mip & mie;

  int_prio_enc #(.XLEN(XLEN)) u_enc (
    .pend  (pend),
    .en    (MIE),
    .valid (int_valid),
    .index (int_index)
  );

  // The interrupt being drained must stay pending and enabled the whole time.
  assign still_pending = pend[cause_q] & MIE;
  assign vec_base      = {mtvec[XLEN-1:2], 2'b00};
  assign vec_offset    = {{(XLEN-7){1'b0}}, cause_q, 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      kind_q  <= INT;
      cause_q <= 5'd0;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state   <= state_n;
      kind_q  <= kind_n;
      cause_q <= cause_n;
      pc_q    <= pc_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    kind_n      = kind_q;
    cause_n     = cause_q;
    pc_n        = pc_q;
    cnt_n       = cnt_q;
    stall_fetch = 1'b0;
    flush       = 1'b0;
    int_action  = 1'b0;
    exp_action  = 1'b0;
    ret_action  = 1'b0;
    int_code    = 5'd0;
    current_pc  = '0;
    redirect    = 1'b0;
    redirect_pc = '0;

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (exc_valid) begin
          state_n = TRAP;
          kind_n  = EXC;
          cause_n = exc_code;
          pc_n    = commit_pc;
        end else if (mret_valid) begin
          state_n = TRAP;
          kind_n  = RET;
          cause_n = 5'd0;
          pc_n    = commit_pc;
        end else if (int_valid) begin
          state_n = DRAIN;
          kind_n  = INT;
          cause_n = int_index;
        end
      end

      DRAIN: begin
        stall_fetch = 1'b1;
        cnt_n       = '0;
        if (exc_valid) begin
          state_n = TRAP;
          kind_n  = EXC;
          cause_n = exc_code;
          pc_n    = commit_pc;
        end else if (!still_pending) begin
          state_n = IDLE;
        end else if (pipe_empty || cnt_q == CNT_W'(DRAIN_MAX - 1)) begin
          state_n = TRAP;
          pc_n    = commit_pc;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end

      TRAP: begin
        stall_fetch = 1'b1;
        flush       = 1'b1;
        int_code    = cause_q;
        current_pc  = pc_q;
        case (kind_q)
          INT:     int_action = 1'b1;
          EXC:     exp_action = 1'b1;
          RET:     ret_action = 1'b1;
          default: ;
        endcase
        state_n = REDIRECT;
      end

      REDIRECT: begin
        stall_fetch = 1'b1;
        redirect    = 1'b1;
        if (kind_q == RET) begin
          redirect_pc = mepc;
        end else if (kind_q == INT && mtvec[1:0] == MTVEC_VECTORED) begin
          redirect_pc = vec_base + vec_offset;
        end else begin
          redirect_pc = vec_base;
        end
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_trap_sequencer.sv
// tb/tb_trap_sequencer.sv - scoreboard bench for trap_sequencer
module tb_trap_sequencer;

  localparam int K_INT = 0;
  localparam int K_EXC = 1;
  localparam int K_RET = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mip, mie, mtvec, mepc, commit_pc;
  logic        mstatus_mie, exc_valid, mret_valid, pipe_empty;
  logic [4:0]  exc_code;
  logic        stall_fetch, flush, int_action, exp_action, ret_action;
  logic [4:0]  int_code;
  logic [31:0] current_pc, redirect_pc;
  logic        redirect, busy;

  trap_sequencer #(.XLEN(32), .DRAIN_MAX(7)) dut (
    .clk(clk), .reset(reset), .mip(mip), .mie(mie), .MIE(mstatus_mie),
    .mtvec(mtvec), .mepc(mepc), .exc_valid(exc_valid), .exc_code(exc_code),
    .mret_valid(mret_valid), .commit_pc(commit_pc), .pipe_empty(pipe_empty),
    .stall_fetch(stall_fetch), .flush(flush), .int_action(int_action),
    .exp_action(exp_action), .ret_action(ret_action), .int_code(int_code),
    .current_pc(current_pc), .redirect(redirect), .redirect_pc(redirect_pc),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          kind;
    logic [4:0]  code;
    logic [31:0] pc;
  } act_t;

  act_t        act_q[$];
  logic [31:0] red_q[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int winner(logic [31:0] p);
    int order[3] = '{11, 3, 7};
    foreach (order[j]) if (p[order[j]]) return order[j];
    for (int i = 16; i < 32; i++) if (p[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] target(int kind, int cause, logic [31:0] tv, logic [31:0] ep);
    logic [31:0] b;
    b = tv & 32'hFFFF_FFFC;
    if (kind == K_RET) return ep;
    if (kind == K_INT && tv[1:0] == 2'b01) return b + 32'(cause * 4);
    return b;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents an action or redirect.
  initial begin
    int   n, k;
    act_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        n = int'(int_action) + int'(exp_action) + int'(ret_action);
        if (n != 0 || flush) begin
          check("pulse_onehot", n, 1);
          check("flush_with_action", flush, 1);
          k = int_action ? K_INT : (exp_action ? K_EXC : K_RET);
          if (act_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_action actual_kind=%0d required=none", k);
          end else begin
            e = act_q.pop_front();
            check("act_kind", k, e.kind);
            if (e.kind != K_RET) begin
              check("act_code", int_code, e.code);
              check("act_pc", current_pc, e.pc);
            end
          end
        end
        if (redirect) begin
          if (red_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_redirect actual=%h required=none", redirect_pc);
          end else begin
            check("redirect_pc", redirect_pc, red_q.pop_front());
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_sync(bit do_exc, bit do_ret, logic [4:0] code, logic [31:0] pc,
                          logic [31:0] tv, logic [31:0] ep);
    int kind;
    kind        = do_exc ? K_EXC : K_RET;
    exc_valid   = do_exc;
    mret_valid  = do_ret;
    exc_code    = code;
    commit_pc   = pc;
    mtvec       = tv;
    mepc        = ep;
    mip         = $urandom;
    mie         = $urandom;
    mstatus_mie = 1'($urandom_range(0, 1));
    act_q.push_back('{kind, code, pc});
    red_q.push_back(target(kind, code, tv, ep));
    cyc();
    check("sync_lat_action", flush && (exp_action || ret_action), 1);
    exc_valid   = 1'b0;
    mret_valid  = 1'b0;
    mip         = '0;
    mstatus_mie = 1'b0;
    cyc();
    check("sync_lat_redirect", redirect, 1);
    cyc();
    check("sync_back_idle", busy, 0);
  endtask

  task automatic run_int(logic [31:0] mip_v, logic [31:0] mie_v, logic [31:0] tv,
                         int k, int off_cycles);
    logic [31:0] pc;
    int w, n;
    pc          = $urandom;
    w           = winner(mip_v & mie_v);
    n           = 0;
    mip         = mip_v;
    mie         = mie_v;
    mtvec       = tv;
    commit_pc   = pc;
    pipe_empty  = 1'b0;
    mstatus_mie = 1'b0;
    for (int i = 0; i < off_cycles; i++) begin
      cyc();
      check("masked_no_busy", {busy, flush, int_action}, 0);
    end
    mstatus_mie = 1'b1;
    act_q.push_back('{K_INT, 5'(w), pc});
    red_q.push_back(target(K_INT, w, tv, mepc));
    cyc();
    check("int_enter_drain", busy && stall_fetch && !flush, 1);
    for (int i = 0; i < 20 && !flush; i++) begin
      n++;
      pipe_empty = (n > k);
      cyc();
    end
    check("drain_len", n, (k + 1 < 7) ? k + 1 : 7);
    mip         = '0;
    mstatus_mie = 1'b0;
    pipe_empty  = 1'b0;
    cyc();
    cyc();
    check("int_back_idle", busy, 0);
  endtask

  task automatic run_abort(bit drop_mie);
    mip         = 32'h80;
    mie         = 32'h80;
    mstatus_mie = 1'b1;
    pipe_empty  = 1'b0;
    cyc();
    check("abort_enter", busy, 1);
    cyc();
    cyc();
    if (drop_mie) mstatus_mie = 1'b0;
    else mip = '0;
    cyc();
    check("abort_idle", {busy, stall_fetch, flush}, 0);
    mip         = '0;
    mstatus_mie = 1'b0;
    cyc();
    check("abort_stays_idle", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] m, e, tv;
    int r;
    reset = 1'b1;
    {mip, mie, mtvec, mepc, commit_pc} = '0;
    {mstatus_mie, exc_valid, mret_valid, pipe_empty} = '0;
    exc_code = '0;
    cyc();
    cyc();
    check("reset_outputs", {stall_fetch, flush, int_action, exp_action, ret_action,
                            redirect, busy, int_code, current_pc | redirect_pc}, 0);
    reset = 1'b0;
    cyc();
    check("post_reset_idle", busy, 0);

    run_sync(1, 0, 5'd2, 32'h100, 32'h2001, 32'h0);
    run_int(32'h888, 32'h888, 32'h2001, 3, 4);
    run_abort(0);
    run_abort(1);
    run_sync(0, 1, 5'd0, 32'h44, 32'h2001, 32'h340);
    run_sync(1, 1, 5'd7, 32'h88, 32'h3000, 32'h340);
    run_int(32'h80, 32'h80, $urandom, 20, 0);

    exc_valid = 1'b1;
    exc_code  = 5'd5;
    commit_pc = 32'h500;
    cyc();
    check("pre_reset_trap", exp_action, 1);
    reset = 1'b1;
    #1;
    check("async_reset_outputs", {stall_fetch, flush, int_action, exp_action, ret_action,
                                  redirect, busy, int_code, current_pc | redirect_pc}, 0);
    exc_valid = 1'b0;
    cyc();
    reset = 1'b0;
    cyc();
    check("reset_trap_idle", {busy, redirect}, 0);

    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 3);
      if (r == 3) begin
        m  = $urandom;
        e  = $urandom;
        if (winner(m & e) < 0) begin
          m[7] = 1'b1;
          e[7] = 1'b1;
        end
        tv = $urandom;
        if ($urandom_range(0, 1) == 1) tv[1:0] = 2'b01;
        run_int(m, e, tv, $urandom_range(0, 9), $urandom_range(0, 2));
      end else begin
        run_sync(r != 1, r != 0, 5'($urandom), $urandom, $urandom, $urandom);
      end
    end

    cyc();
    check("act_q_empty", act_q.size(), 0);
    check("red_q_empty", red_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
